// File: rtl/mem_cmd_if.sv
// mem_cmd_if: request/acknowledge bus between the command sequencer and the
// memory device.
//   mem_req   : transaction request (sequencer -> memory)
//   mem_we    : 1 = write, 0 = read, valid while mem_req
//   mem_addr  : transaction address
//   mem_wdata : write data
//   mem_ack   : memory completes the transaction when mem_req && mem_ack
//   mem_rdata : read data, valid in the ack cycle of a read
// Modports: master = sequencer side, slave = memory side.
interface mem_cmd_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_cmd_sequencer.sv
// mem_cmd_sequencer: runs single write/read transactions and whole-range
// clear commands for the front-panel I/O controller over a req/ack memory bus.
//   clk, rst_n        : clock, asynchronous active-low reset
//   io_done           : command strobe, a start is its rising edge
//   io_mode           : 00 clear, 01 read, 10 write, 11 none
//   io_addr, io_wdata : address / write data, sampled at start
//   ready             : idle and accepting a start
//   rd_data, rd_valid : last read result, one-cycle pulse when it updates
//   err               : sticky timeout flag, cleared by the next accepted start
//   clr_busy          : a clear command is in progress
//   mem               : memory bus (master side)
module mem_cmd_sequencer #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int CLEAR_LAST  = 2**25-1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_done,
  input  logic [1:0]        io_mode,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err,
  output logic              clr_busy,
  mem_cmd_if.master         mem
);

  // Counter holds 0..TIMEOUT_CYC-1; +1 keeps it at least one bit wide.
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CLEAR_LAST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              io_done_q;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start;

  assign start = io_done & ~io_done_q;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Mode 11 is not a command: nothing is launched and err is kept.
        if (start && io_mode != 2'b11) begin
          err_d = 1'b0;
          req_d = 1'b1;
          case (io_mode)
            2'b10: begin
              we_d    = 1'b1;
              addr_d  = io_addr;
              wdata_d = io_wdata;
              state_d = ST_XFER;
            end
            2'b01: begin
              we_d    = 1'b0;
              addr_d  = io_addr;
              wdata_d = io_wdata;
              state_d = ST_XFER;
            end
            default: begin
              we_d    = 1'b1;
              addr_d  = '0;
              wdata_d = '0;
              state_d = ST_CLEAR;
            end
          endcase
        end
      end

      ST_XFER, ST_CLEAR: begin
        // An ack is checked first so it wins over a simultaneous timeout.
        if (mem.mem_ack) begin
          cnt_d = '0;
          if (state_q == ST_XFER) begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
            if (!we_q) begin
              rd_data_d  = mem.mem_rdata;
              rd_valid_d = 1'b1;
            end
          end else if (addr_q == ADDR_LAST) begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          // This is the TIMEOUT_CYC-th request cycle without an ack.
          cnt_d   = '0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        req_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      io_done_q  <= 1'b1;   // io_done held high through reset is not a start
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      io_done_q  <= io_done;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ready         = (state_q == ST_IDLE);
  assign clr_busy      = (state_q == ST_CLEAR);
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign err           = err_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// tb_mem_cmd_sequencer: bench for mem_cmd_sequencer with a transaction-level
// reference model, a per-cycle compare process, directed scenarios with
// literal expectations, and a randomized phase.
module tb_mem_cmd_sequencer;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int CL = 15;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          io_done = 1'b0;
  logic [1:0]    io_mode = 2'b11;
  logic [AW-1:0] io_addr = '0;
  logic [DW-1:0] io_wdata = '0;
  logic          ready, rd_valid, err, clr_busy;
  logic [DW-1:0] rd_data;

  mem_cmd_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  mem_cmd_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_LAST(CL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .io_done(io_done), .io_mode(io_mode),
    .io_addr(io_addr), .io_wdata(io_wdata), .ready(ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .err(err), .clr_busy(clr_busy), .mem(mem_bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // One outstanding command at most; m_waited counts request cycles
  // without ack for the current beat.
  logic          m_done_q, m_busy, m_clear, m_we, m_rd_valid, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd_data;
  int            m_waited;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done_q <= 1'b1; m_busy <= 1'b0; m_clear <= 1'b0; m_we <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rd_data <= '0; m_rd_valid <= 1'b0;
      m_err <= 1'b0; m_waited <= 0;
    end else begin
      m_done_q   <= io_done;
      m_rd_valid <= 1'b0;
      if (!m_busy) begin
        m_waited <= 0;
        if (io_done && !m_done_q && io_mode != 2'b11) begin
          m_busy  <= 1'b1;
          m_err   <= 1'b0;
          m_clear <= (io_mode == 2'b00);
          m_we    <= (io_mode != 2'b01);
          m_addr  <= (io_mode == 2'b00) ? '0 : io_addr;
          m_wdata <= (io_mode == 2'b00) ? '0 : io_wdata;
        end
      end else if (mem_bus.mem_ack) begin
        m_waited <= 0;
        if (!m_clear) begin
          m_busy <= 1'b0;
          if (!m_we) begin
            m_rd_data  <= mem_bus.mem_rdata;
            m_rd_valid <= 1'b1;
          end
        end else if (m_addr == AW'(CL)) begin
          m_busy <= 1'b0;
        end else begin
          m_addr <= m_addr + 1'b1;
        end
      end else if (m_waited + 1 == TO) begin
        m_busy   <= 1'b0;
        m_err    <= 1'b1;
        m_waited <= 0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("ready",    32'(ready),            32'(!m_busy));
        chk("mem_req",  32'(mem_bus.mem_req),  32'(m_busy));
        chk("clr_busy", 32'(clr_busy),         32'(m_busy && m_clear));
        chk("err",      32'(err),              32'(m_err));
        chk("rd_valid", 32'(rd_valid),         32'(m_rd_valid));
        chk("rd_data",  32'(rd_data),          32'(m_rd_data));
        if (m_busy) begin
          chk("mem_we",   32'(mem_bus.mem_we),   32'(m_we));
          chk("mem_addr", 32'(mem_bus.mem_addr), 32'(m_addr));
          if (m_we) chk("mem_wdata", 32'(mem_bus.mem_wdata), 32'(m_wdata));
        end
      end
    end
  end

  // ---------------- statistics monitor ----------------
  int            st_req = 0, st_rdv = 0, st_busy = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic          last_we = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_bus.mem_req) begin
        st_req++;
        last_addr  = mem_bus.mem_addr;
        last_wdata = mem_bus.mem_wdata;
        last_we    = mem_bus.mem_we;
      end
      if (rd_valid) st_rdv++;
      if (clr_busy) st_busy++;
    end
  end

  // ---------------- memory responder ----------------
  logic          ack_random = 1'b0;
  int            ack_delay = 0;
  logic          rdata_fix_en = 1'b0;
  logic [DW-1:0] rdata_fix = '0;

  initial begin
    int wcnt;
    wcnt = 0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_bus.mem_rdata = rdata_fix_en ? rdata_fix : DW'($urandom);
      if (ack_random) begin
        mem_bus.mem_ack = ($urandom_range(0, 2) == 0);
      end else if (ack_delay == 0) begin
        mem_bus.mem_ack = 1'b1;
      end else if (!mem_bus.mem_req) begin
        wcnt = 0;
        mem_bus.mem_ack = 1'b0;
      end else begin
        mem_bus.mem_ack = (wcnt >= ack_delay);
        wcnt = mem_bus.mem_ack ? 0 : wcnt + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_cmd(input logic [1:0] mode, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    io_mode = mode; io_addr = a; io_wdata = d; io_done = 1'b1;
    @(negedge clk);
    // Scramble the inputs to show the in-flight command was latched.
    io_done = 1'b0; io_mode = ~mode; io_addr = ~a; io_wdata = ~d;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (ready) begin
        repeat (2) @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: got busy after 2000 cycles expected ready", name);
  endtask

  int s_req, s_rdv, s_busy;

  task automatic snap();
    s_req = st_req; s_rdv = st_rdv; s_busy = st_busy;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_req",   32'(mem_bus.mem_req), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_rdata", 32'(rd_data), 32'd0);
    chk("rst_clr",   32'(clr_busy), 32'd0);

    // Write, ack on the 4th request cycle
    ack_delay = 3;
    snap();
    do_cmd(2'b10, 25'h1ABCDEF, 16'hBEEF);
    wait_idle("wr_done");
    $display("write: addr=%0h data=%0h req_cycles=%0d", last_addr, last_wdata, st_req - s_req);
    chk("wr_req_cycles", 32'(st_req - s_req), 32'd4);
    chk("wr_addr",  32'(last_addr), 32'h1ABCDEF);
    chk("wr_data",  32'(last_wdata), 32'hBEEF);
    chk("wr_we",    32'(last_we), 32'd1);
    chk("wr_no_rdv", 32'(st_rdv - s_rdv), 32'd0);

    // Read, immediate ack
    ack_delay = 0; rdata_fix_en = 1'b1; rdata_fix = 16'h5A5A;
    do_cmd(2'b01, 25'h0000012, 16'h0);
    chk("rd_busy_s1", 32'(ready), 32'd0);
    @(negedge clk);
    chk("rd_ready_s2", 32'(ready), 32'd1);
    chk("rd_valid_s2", 32'(rd_valid), 32'd1);
    chk("rd_data_s2",  32'(rd_data), 32'h5A5A);
    @(negedge clk);
    chk("rd_valid_s3", 32'(rd_valid), 32'd0);
    $display("read: addr=12 data=%0h", rd_data);
    rdata_fix_en = 1'b0;

    // Clear with ack tied high, second io_done edge mid-clear is dropped
    snap();
    do_cmd(2'b00, 25'h0, 16'h0);
    repeat (3) @(negedge clk);
    io_mode = 2'b10; io_addr = 25'h77; io_wdata = 16'h1234; io_done = 1'b1;
    @(negedge clk);
    io_done = 1'b0;
    wait_idle("clr_done");
    $display("clear: beats=%0d busy_cycles=%0d last_addr=%0h", st_req - s_req, st_busy - s_busy, last_addr);
    chk("clr_beats", 32'(st_req - s_req), 32'd16);
    chk("clr_busy_cycles", 32'(st_busy - s_busy), 32'd16);
    chk("clr_last_addr", 32'(last_addr), 32'd15);
    chk("clr_last_data", 32'(last_wdata), 32'd0);

    // Timeout on a read: rd_data keeps 5A5A
    ack_delay = 1000;
    snap();
    do_cmd(2'b01, 25'h33, 16'h0);
    wait_idle("to_done");
    $display("timeout: req_cycles=%0d err=%0d rd_data=%0h", st_req - s_req, err, rd_data);
    chk("to_req_cycles", 32'(st_req - s_req), 32'd8);
    chk("to_err",   32'(err), 32'd1);
    chk("to_rdata", 32'(rd_data), 32'h5A5A);
    chk("to_no_rdv", 32'(st_rdv - s_rdv), 32'd0);

    // Mode 11 leaves err alone and issues nothing
    snap();
    do_cmd(2'b11, 25'h5, 16'h5);
    repeat (3) @(negedge clk);
    chk("none_err", 32'(err), 32'd1);
    chk("none_req", 32'(st_req - s_req), 32'd0);

    // Write clears err on acceptance
    ack_delay = 0;
    do_cmd(2'b10, 25'h44, 16'hCAFE);
    chk("wr_clr_err", 32'(err), 32'd0);
    wait_idle("wr2_done");
    $display("write after timeout: err=%0d", err);

    // io_done held high across reset release
    snap();
    @(negedge clk);
    io_done = 1'b1; io_mode = 2'b10;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_no_req", 32'(st_req - s_req), 32'd0);
    chk("held_ready",  32'(ready), 32'd1);
    io_done = 1'b0;
    @(negedge clk);
    $display("reset with io_done held: req_cycles=%0d", st_req - s_req);

    // Asynchronous reset in the middle of a slow clear
    ack_delay = 2;
    do_cmd(2'b00, 25'h0, 16'h0);
    repeat (8) @(negedge clk);
    chk("mid_clr_busy", 32'(clr_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   32'(mem_bus.mem_req), 32'd0);
    chk("arst_clr",   32'(clr_busy), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    $display("async reset mid-clear: req=%0d clr_busy=%0d ready=%0d", mem_bus.mem_req, clr_busy, ready);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized phase: strobes at any time, random modes, random acks
    ack_random = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) io_done = ~io_done;
      io_mode  = 2'($urandom);
      io_addr  = AW'($urandom);
      io_wdata = DW'($urandom);
    end
    io_done = 1'b0;
    wait_idle("rand_done");
    $display("random phase: %0d request cycles, %0d reads", st_req, st_rdv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
